ctrl_inv: RTL and testbench



---
 rtl/ctrl_inv_pkg.sv | 28 ++
 rtl/ctrl_inv.sv | 143 ++++++++++++++
 tb/tb_ctrl_inv.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ctrl_inv_pkg.sv
// rtl/ctrl_inv_pkg.sv - shared AES inverse-cipher state codes and FSM states
// The cs code values are also consumed by the downstream inverse datapath.
package ctrl_inv_pkg;

  localparam logic [2:0] CS_RES = 3'b000;
  localparam logic [2:0] CS_STL = 3'b001;
  localparam logic [2:0] CS_ADD = 3'b010;
  localparam logic [2:0] CS_SUB = 3'b011;
  localparam logic [2:0] CS_SHI = 3'b100;
  localparam logic [2:0] CS_MIX = 3'b101;
  localparam logic [2:0] CS_INV = 3'b110;
  localparam logic [2:0] CS_FIN = 3'b111;

  localparam int NR_DEFAULT = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STL,
    ST_KEXP,
    ST_ARK0,
    ST_SHI,
    ST_SUB,
    ST_ADD,
    ST_MIX,
    ST_FIN
  } state_t;

endpackage

// File: rtl/ctrl_inv.sv
// rtl/ctrl_inv.sv - control FSM for the AES-128 inverse cipher datapath
// Outputs are decoded from the current state and registered, so they trail the state by one cycle.
module ctrl_inv
  import ctrl_inv_pkg::*;
#(
  parameter int NR = NR_DEFAULT,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [2:0]    cs,
  output logic [CW-1:0] count,
  output logic          load_sel,
  output logic          busy,
  output logic          done
);

  localparam logic [3:0]    NR4   = 4'(NR);
  localparam logic [CW-1:0] NR_CW = CW'(NR);

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    step_q, step_d;
  logic [2:0]    cs_q, cs_d;
  logic [CW-1:0] count_q, count_d;
  logic          load_sel_q, load_sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    step_d     = step_q;
    cs_d       = CS_RES;
    count_d    = '0;
    load_sel_d = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_STL;
      end
      ST_STL: begin
        cs_d    = CS_STL;
        busy_d  = 1'b1;
        step_d  = 4'd1;
        state_d = ST_KEXP;
      end
      ST_KEXP: begin
        // Forward key expansion walks count 1..NR to reach the last round key.
        cs_d       = CS_INV;
        count_d    = CW'(step_q);
        load_sel_d = 1'b0;
        busy_d     = 1'b1;
        if (step_q >= NR4) begin
          round_d = NR4 - 4'd1;
          state_d = ST_ARK0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      ST_ARK0: begin
        cs_d       = CS_ADD;
        count_d    = NR_CW;
        load_sel_d = 1'b0;
        busy_d     = 1'b1;
        state_d    = ST_SHI;
      end
      ST_SHI, ST_SUB, ST_ADD, ST_MIX: begin
        count_d    = CW'(round_q + 4'd1);
        load_sel_d = 1'b0;
        busy_d     = 1'b1;
        case (state_q)
          ST_SHI: begin
            cs_d    = CS_SHI;
            state_d = ST_SUB;
          end
          ST_SUB: begin
            cs_d    = CS_SUB;
            state_d = ST_ADD;
          end
          ST_ADD: begin
            cs_d    = CS_ADD;
            state_d = (round_q == 4'd0) ? ST_FIN : ST_MIX;
          end
          default: begin
            // Round 0 exits from ADD, so MIX always sees round_q >= 1.
            cs_d = CS_MIX;
            if (round_q == 4'd0) begin
              state_d = ST_IDLE;
            end else begin
              round_d = round_q - 4'd1;
              state_d = ST_SHI;
            end
          end
        endcase
      end
      ST_FIN: begin
        cs_d       = CS_FIN;
        load_sel_d = 1'b0;
        // cs_q still shows the last ADD during the first FIN state cycle.
        done_d     = (cs_q != CS_FIN);
        if (start) state_d = ST_STL;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
        step_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round_q    <= 4'd0;
      step_q     <= 4'd0;
      cs_q       <= CS_RES;
      count_q    <= '0;
      load_sel_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      step_q     <= step_d;
      cs_q       <= cs_d;
      count_q    <= count_d;
      load_sel_q <= load_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cs       = cs_q;
  assign count    = count_q;
  assign load_sel = load_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ctrl_inv.sv
// tb/tb_ctrl_inv.sv - scoreboard bench for ctrl_inv against a schedule-offset reference model
module tb_ctrl_inv;
  import ctrl_inv_pkg::*;

  localparam int NR  = 10;
  localparam int CW  = 8;
  localparam int LAT = 5 * NR + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    cs;
  logic [CW-1:0] count;
  logic          load_sel;
  logic          busy;
  logic          done;

  ctrl_inv #(.NR(NR), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cs       (cs),
    .count    (count),
    .load_sel (load_sel),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    cs;
    logic [CW-1:0] count;
    logic          load_sel;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference: k is the 1-based cycle offset since the accepted start (1 = STL, LAT = FIN).
  bit run = 1'b0;
  bit pend = 1'b0;
  int k = 0;

  function automatic exp_t model_out(bit on, int kk);
    exp_t e;
    int j, r;
    logic [2:0] sub_codes [4];
    sub_codes[0] = CS_SHI; sub_codes[1] = CS_SUB; sub_codes[2] = CS_ADD; sub_codes[3] = CS_MIX;
    e = '{cs: CS_RES, count: '0, load_sel: 1'b1, busy: 1'b0, done: 1'b0};
    if (!on) return e;
    if (kk == 1) begin
      e.cs = CS_STL; e.busy = 1'b1;
    end else if (kk <= NR + 1) begin
      e.cs = CS_INV; e.count = CW'(kk - 1); e.load_sel = 1'b0; e.busy = 1'b1;
    end else if (kk == NR + 2) begin
      e.cs = CS_ADD; e.count = CW'(NR); e.load_sel = 1'b0; e.busy = 1'b1;
    end else if (kk < LAT) begin
      j = kk - (NR + 3);
      r = NR - 1 - j / 4;
      e.cs = sub_codes[j % 4]; e.count = CW'(r + 1); e.load_sel = 1'b0; e.busy = 1'b1;
    end else begin
      e.cs = CS_FIN; e.load_sel = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) begin : ref_model
    bit entered;
    exp_t e;
    entered = 1'b0;
    if (rst) begin
      run = 1'b0; pend = 1'b0; k = 0;
    end else if (pend) begin
      run = 1'b1; k = 1; pend = 1'b0;
    end else if (run && k < LAT) begin
      k++;
      entered = (k == LAT);
    end
    e = model_out(run, k);
    e.done = entered;
    sb_q.push_back(e);
    if (!rst && start && (!run || k == LAT)) pend = 1'b1;
  end

  always @(negedge clk) begin : monitor
    exp_t e, a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {cs, count, load_sel, busy, done};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs cyc %0d: got cs=%b count=%0d load_sel=%b busy=%b done=%b, want cs=%b count=%0d load_sel=%b busy=%b done=%b",
                 cyc, a.cs, a.count, a.load_sel, a.busy, a.done, e.cs, e.count, e.load_sel, e.busy, e.done);
      end
    end
    cyc++;
  end

  task automatic step(input bit r, input bit s, input int n);
    repeat (n) begin
      rst = r;
      start = s;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset then idle
    step(1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 20);
    // Full trace from a single start pulse
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 60);
    // Start pulses while busy are ignored
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 4);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 24);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 40);
    // Reset mid-operation, then a fresh run
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 19);
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 3);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 60);
    // Start held high: back-to-back runs through a one-cycle FIN
    step(1'b0, 1'b1, 110);
    step(1'b0, 1'b0, 5);
    // Randomized start / reset traffic
    repeat (800) step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, 1);
    step(1'b0, 1'b0, 2);
    @(negedge clk);
    #1;
    vectors++;
    if (sb_q.size() > 1) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending entries, want at most 1", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
